// File: rtl/el2_dccm_sram_sink_pkg.sv
// Shared constants, FSM encoding and the error-injection mask helper for the
// DCCM SRAM sink.
package el2_dccm_sram_sink_pkg;

  localparam int DCCM_DATA_W = 32;
  localparam int DCCM_ECC_W  = 7;
  localparam int DCCM_WORD_W = DCCM_DATA_W + DCCM_ECC_W;
  localparam int INJ_BIT_W   = 6;

  // One stored row: {ecc, data}
  typedef logic [DCCM_WORD_W-1:0] dccm_word_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } dccm_state_e;

  // True when the requested bit index lands inside the 39-bit {ecc,data} word.
  function automatic logic inj_bit_valid(input logic [INJ_BIT_W-1:0] bit_idx);
    return (int'(bit_idx) < DCCM_WORD_W);
  endfunction

  // One-hot XOR mask for the selected bit. Out-of-range indices shift the
  // single 1 off the top of the word and yield an all-zero mask.
  function automatic dccm_word_t inj_mask(input logic [INJ_BIT_W-1:0] bit_idx);
    return dccm_word_t'(1) << bit_idx;
  endfunction

endpackage

// File: rtl/el2_dccm_sram_sink_if.sv
// Per-bank DCCM SRAM port bundle between the core memory wrapper (master)
// and the SRAM sink (slave). Vectors are flat, bank 0 in the low slice.
interface el2_dccm_sram_sink_if
  import el2_dccm_sram_sink_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10
);

  logic [NUM_BANKS-1:0]             dccm_clken;
  logic [NUM_BANKS-1:0]             dccm_wren_bank;
  logic [NUM_BANKS*ADDR_W-1:0]      dccm_addr_bank;
  logic [NUM_BANKS*DCCM_DATA_W-1:0] dccm_wr_data_bank;
  logic [NUM_BANKS*DCCM_ECC_W-1:0]  dccm_wr_ecc_bank;
  logic [NUM_BANKS*DCCM_DATA_W-1:0] dccm_bank_dout;
  logic [NUM_BANKS*DCCM_ECC_W-1:0]  dccm_bank_ecc;

  modport master (
    output dccm_clken,
    output dccm_wren_bank,
    output dccm_addr_bank,
    output dccm_wr_data_bank,
    output dccm_wr_ecc_bank,
    input  dccm_bank_dout,
    input  dccm_bank_ecc
  );

  modport slave (
    input  dccm_clken,
    input  dccm_wren_bank,
    input  dccm_addr_bank,
    input  dccm_wr_data_bank,
    input  dccm_wr_ecc_bank,
    output dccm_bank_dout,
    output dccm_bank_ecc
  );

endinterface

// File: rtl/el2_dccm_sram_bank.sv
// Single 1RW DCCM bank: DEPTH x 39-bit array with a registered read port.
// A write leaves the output register untouched; only reads update it.
module el2_dccm_sram_bank
  import el2_dccm_sram_sink_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  dccm_word_t        wdata_i,
  output dccm_word_t        rdata_o
);

  dccm_word_t mem_q [DEPTH];
  dccm_word_t rdata_q;

  // Array write port; no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read; the output register alone is cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/el2_dccm_sram_sink.sv
// DCCM SRAM sink: NUM_BANKS independent 1RW banks behind the core's exported
// SRAM interface, a zero-init sequencer that owns every bank port until all
// rows are cleared, and a one-shot error-injection register that flips one
// bit of a single selected read on its way out.
module el2_dccm_sram_sink
  import el2_dccm_sram_sink_pkg::*;
#(
  parameter int DCCM_NUM_BANKS   = 4,
  parameter int DCCM_INDEX_DEPTH = 1024,
  parameter int ADDR_W           = $clog2(DCCM_INDEX_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_l,
  el2_dccm_sram_sink_if.slave               bus,
  output logic                              init_done,
  input  logic                              inj_arm,
  input  logic [$clog2(DCCM_NUM_BANKS)-1:0] inj_bank,
  input  logic [ADDR_W-1:0]                 inj_row,
  input  logic [INJ_BIT_W-1:0]              inj_bit,
  output logic                              inj_pending
);

  localparam int                BANK_W   = $clog2(DCCM_NUM_BANKS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DCCM_INDEX_DEPTH - 1);

  dccm_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    row_q, row_d;

  logic                 inj_pending_q, inj_pending_d;
  logic [BANK_W-1:0]    inj_bank_q, inj_bank_d;
  logic [ADDR_W-1:0]    inj_row_q, inj_row_d;
  logic [INJ_BIT_W-1:0] inj_bit_q, inj_bit_d;

  logic                 arm_valid;
  logic                 in_init;
  dccm_word_t           inj_word_mask;

  logic [DCCM_NUM_BANKS-1:0]                  bank_rd;
  logic [DCCM_NUM_BANKS-1:0]                  inj_hit;
  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_W-1:0] dout_w;
  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_W-1:0]  ecc_w;

  // State and init row counter; reset always restarts the clear from row 0
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= INIT;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Next state: sweep one row per cycle, leave INIT after the last row
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      INIT: begin
        row_d = row_q + ADDR_W'(1);
        if (row_q == LAST_ROW) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        row_d   = '0;
      end
    endcase
  end

  assign in_init   = (state_q == INIT);
  assign init_done = (state_q == READY);

  // An arm request with an index outside the 39-bit word is dropped entirely
  assign arm_valid     = inj_arm && inj_bit_valid(inj_bit);
  assign inj_word_mask = inj_mask(inj_bit_q);

  // Injection request: a new arm always wins over a same-cycle matching read
  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_bank_d    = inj_bank_q;
    inj_row_d     = inj_row_q;
    inj_bit_d     = inj_bit_q;
    if (arm_valid) begin
      inj_pending_d = 1'b1;
      inj_bank_d    = inj_bank;
      inj_row_d     = inj_row;
      inj_bit_d     = inj_bit;
    end else if (|inj_hit) begin
      inj_pending_d = 1'b0;
    end
  end

  // Injection register bank
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      inj_pending_q <= 1'b0;
      inj_bank_q    <= '0;
      inj_row_q     <= '0;
      inj_bit_q     <= '0;
    end else begin
      inj_pending_q <= inj_pending_d;
      inj_bank_q    <= inj_bank_d;
      inj_row_q     <= inj_row_d;
      inj_bit_q     <= inj_bit_d;
    end
  end

  assign inj_pending = inj_pending_q;

  for (genvar gi = 0; gi < DCCM_NUM_BANKS; gi++) begin : g_bank
    logic              core_en;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    dccm_word_t        core_wdata;
    logic              bank_en;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_addr;
    dccm_word_t        bank_wdata;
    dccm_word_t        bank_rdata;
    dccm_word_t        flip_q;
    dccm_word_t        out_word;

    assign core_en    = bus.dccm_clken[gi];
    assign core_we    = bus.dccm_wren_bank[gi];
    assign core_addr  = bus.dccm_addr_bank[gi*ADDR_W +: ADDR_W];
    assign core_wdata = {bus.dccm_wr_ecc_bank[gi*DCCM_ECC_W +: DCCM_ECC_W],
                         bus.dccm_wr_data_bank[gi*DCCM_DATA_W +: DCCM_DATA_W]};

    // During INIT the sequencer owns the port and the core request is dropped
    assign bank_en    = in_init ? 1'b1  : core_en;
    assign bank_we    = in_init ? 1'b1  : core_we;
    assign bank_addr  = in_init ? row_q : core_addr;
    assign bank_wdata = in_init ? '0    : core_wdata;

    assign bank_rd[gi] = !in_init && core_en && !core_we;
    assign inj_hit[gi] = bank_rd[gi] && inj_pending_q && !inj_arm
                      && (inj_bank_q == BANK_W'(gi)) && (core_addr == inj_row_q);

    el2_dccm_sram_bank #(
      .DEPTH  (DCCM_INDEX_DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst_l   (rst_l),
      .en_i    (bank_en),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata)
    );

    // Flip mask travels with the read data and holds while dout holds
    always_ff @(posedge clk) begin
      if (!rst_l) begin
        flip_q <= '0;
      end else if (bank_rd[gi]) begin
        flip_q <= inj_hit[gi] ? inj_word_mask : '0;
      end
    end

    assign out_word   = bank_rdata ^ flip_q;
    assign dout_w[gi] = out_word[DCCM_DATA_W-1:0];
    assign ecc_w[gi]  = out_word[DCCM_WORD_W-1:DCCM_DATA_W];
  end

  assign bus.dccm_bank_dout = dout_w;
  assign bus.dccm_bank_ecc  = ecc_w;

endmodule

// File: tb/tb_el2_dccm_sram_sink.sv
// Directed bench for el2_dccm_sram_sink. Reads push their expected {ecc,data}
// into a scoreboard queue; a monitor pops one entry per read bank right after
// the edge that returns the data. State checks are done inline on negedges.
module tb_el2_dccm_sram_sink;
  import el2_dccm_sram_sink_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(NB);

  typedef struct packed {
    logic [7:0] bank;
    dccm_word_t word;
  } sb_item_t;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          init_done;
  logic          inj_arm;
  logic [BW-1:0] inj_bank;
  logic [AW-1:0] inj_row;
  logic [5:0]    inj_bit;
  logic          inj_pending;

  logic [NB-1:0] rd_issue;
  logic [NB-1:0] mon_issued;
  sb_item_t      sb[$];
  int            checks = 0;
  int            passed = 0;

  el2_dccm_sram_sink_if #(.NUM_BANKS(NB), .ADDR_W(AW)) bus ();

  el2_dccm_sram_sink #(
    .DCCM_NUM_BANKS   (NB),
    .DCCM_INDEX_DEPTH (DEPTH),
    .ADDR_W           (AW)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .bus         (bus),
    .init_done   (init_done),
    .inj_arm     (inj_arm),
    .inj_bank    (inj_bank),
    .inj_row     (inj_row),
    .inj_bit     (inj_bit),
    .inj_pending (inj_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  function automatic dccm_word_t word_of(input int b);
    return {bus.dccm_bank_ecc[b*7 +: 7], bus.dccm_bank_dout[b*32 +: 32]};
  endfunction

  task automatic set_wr(input int b, input int row, input logic [31:0] d, input logic [6:0] e);
    bus.dccm_clken[b]               = 1'b1;
    bus.dccm_wren_bank[b]           = 1'b1;
    bus.dccm_addr_bank[b*AW +: AW]  = AW'(row);
    bus.dccm_wr_data_bank[b*32 +: 32] = d;
    bus.dccm_wr_ecc_bank[b*7 +: 7]  = e;
  endtask

  // Must be called in ascending bank order within one cycle
  task automatic set_rd(input int b, input int row, input logic [31:0] d, input logic [6:0] e);
    bus.dccm_clken[b]              = 1'b1;
    bus.dccm_wren_bank[b]          = 1'b0;
    bus.dccm_addr_bank[b*AW +: AW] = AW'(row);
    rd_issue[b]                    = 1'b1;
    sb.push_back('{bank: 8'(b), word: {e, d}});
  endtask

  task automatic arm(input int b, input int row, input int bit_idx);
    inj_arm  = 1'b1;
    inj_bank = BW'(b);
    inj_row  = AW'(row);
    inj_bit  = 6'(bit_idx);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.dccm_clken     = '0;
    bus.dccm_wren_bank = '0;
    rd_issue           = '0;
    inj_arm            = 1'b0;
  endtask

  // Called right after rst_l rises on a negedge; issues one core write
  // during INIT (which must be dropped) and times the rise of init_done.
  task automatic wait_init(input string name, input int wr_k, input int wr_b, input int wr_row);
    int rise;
    rise = -1;
    for (int k = 1; k <= DEPTH + 20; k++) begin
      if (k == wr_k) set_wr(wr_b, wr_row, 32'hA5A5_A5A5, 7'h55);
      tick();
      if (k == DEPTH - 1) check({name, "_early"}, 64'(init_done), 64'd0);
      if (init_done && rise < 0) rise = k;
      if (rise >= 0) break;
    end
    // rise counts edges after release; init_done is seen in cycle rise+1
    check(name, 64'(rise + 1), 64'(DEPTH + 1));
  endtask

  // Scoreboard monitor
  initial begin
    sb_item_t e;
    forever begin
      @(posedge clk);
      mon_issued = rd_issue;
      #1;
      for (int b = 0; b < NB; b++) begin
        if (mon_issued[b]) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL sb_underflow: bank %0d returned data with nothing expected", b);
          end else begin
            e = sb.pop_front();
            $display("rd bank %0d: got ecc=%h data=%h, exp ecc=%h data=%h",
                     b, word_of(b) >> 32, word_of(b) & 39'hFFFF_FFFF, e.word >> 32, e.word & 39'hFFFF_FFFF);
            check($sformatf("rd_bank%0d_word", b), 64'(word_of(b)), 64'(e.word));
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    rst_l                 = 1'b0;
    bus.dccm_clken        = '0;
    bus.dccm_wren_bank    = '0;
    bus.dccm_addr_bank    = '0;
    bus.dccm_wr_data_bank = '0;
    bus.dccm_wr_ecc_bank  = '0;
    rd_issue              = '0;
    inj_arm               = 1'b0;
    inj_bank              = '0;
    inj_row               = '0;
    inj_bit               = '0;

    // Reset with core traffic present
    set_wr(0, 3, 32'h1234_5678, 7'h3C);
    tick();
    tick();
    tick();
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_pending", 64'(inj_pending), 64'd0);
    for (int b = 0; b < NB; b++) check($sformatf("rst_word_b%0d", b), 64'(word_of(b)), 64'd0);

    // First init; core write to bank 0 row 3 after row 3 was cleared
    rst_l = 1'b1;
    wait_init("init_done_rise", 10, 0, 3);

    // Last row cleared, dropped INIT write not stored
    set_rd(0, 3, 32'h0, 7'h0);
    set_rd(2, 1023, 32'h0, 7'h0);
    tick();

    // Data path
    set_wr(0, 9, 32'h0BAD_F00D, 7'h11);
    set_wr(2, 100, 32'hCAFE_F00D, 7'h05);
    set_wr(3, 1023, 32'hFFFF_FFFF, 7'h7F);
    tick();
    set_rd(0, 9, 32'h0BAD_F00D, 7'h11);
    set_wr(1, 5, 32'hDEAD_BEEF, 7'h2A);
    set_rd(2, 100, 32'hCAFE_F00D, 7'h05);
    tick();
    check("wr_holds_dout_b1", 64'(word_of(1)), 64'd0);
    set_rd(1, 5, 32'hDEAD_BEEF, 7'h2A);
    tick();
    check("hold_b0", 64'(word_of(0)), 64'({7'h11, 32'h0BAD_F00D}));
    check("hold_b2", 64'(word_of(2)), 64'({7'h05, 32'hCAFE_F00D}));
    set_rd(0, 9, 32'h0BAD_F00D, 7'h11);
    set_rd(1, 5, 32'hDEAD_BEEF, 7'h2A);
    set_rd(2, 100, 32'hCAFE_F00D, 7'h05);
    set_rd(3, 1023, 32'hFFFF_FFFF, 7'h7F);
    tick();

    // Injection on bank 0 row 7, bit 3
    set_wr(0, 6, 32'h1111_1111, 7'h01);
    tick();
    set_wr(0, 7, 32'h1234_5678, 7'h00);
    tick();
    arm(0, 7, 3);
    tick();
    check("pending_after_arm", 64'(inj_pending), 64'd1);
    set_rd(0, 6, 32'h1111_1111, 7'h01);
    set_rd(1, 7, 32'h0, 7'h0);
    tick();
    check("pending_after_miss", 64'(inj_pending), 64'd1);
    set_rd(0, 7, 32'h1234_5670, 7'h00);
    tick();
    check("pending_after_hit", 64'(inj_pending), 64'd0);
    set_rd(0, 7, 32'h1234_5678, 7'h00);
    tick();

    // ECC bit 35 -> ecc bit 3
    arm(0, 7, 35);
    tick();
    set_rd(0, 7, 32'h1234_5678, 7'h08);
    tick();
    check("pending_after_ecc_hit", 64'(inj_pending), 64'd0);

    // Out-of-range bit is discarded
    arm(0, 7, 40);
    tick();
    check("pending_bit40", 64'(inj_pending), 64'd0);
    set_rd(0, 7, 32'h1234_5678, 7'h00);
    tick();

    // Arm colliding with a matching read: read clean, new request kept
    arm(0, 7, 0);
    tick();
    arm(0, 7, 1);
    set_rd(0, 7, 32'h1234_5678, 7'h00);
    tick();
    check("pending_after_collision", 64'(inj_pending), 64'd1);
    set_rd(0, 7, 32'h1234_567A, 7'h00);
    tick();
    check("pending_after_bit1_hit", 64'(inj_pending), 64'd0);

    // Reset from READY clears outputs and a pending request
    arm(3, 2, 0);
    tick();
    check("pending_before_reset", 64'(inj_pending), 64'd1);
    rst_l = 1'b0;
    tick();
    tick();
    check("rst2_pending", 64'(inj_pending), 64'd0);
    check("rst2_init_done", 64'(init_done), 64'd0);
    for (int b = 0; b < NB; b++) check($sformatf("rst2_word_b%0d", b), 64'(word_of(b)), 64'd0);

    // Reset pulsed around init row 500, then full restart
    rst_l = 1'b1;
    for (int k = 0; k < 500; k++) tick();
    check("midinit_init_done", 64'(init_done), 64'd0);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    wait_init("init_done_rise_after_midreset", 700, 2, 600);

    // Re-init cleared old data; INIT write to bank 2 row 600 dropped
    set_rd(1, 5, 32'h0, 7'h0);
    set_rd(2, 600, 32'h0, 7'h0);
    tick();
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
